// File: rtl/util_dac_underflow_guard_pkg.sv
// Shared types and helpers for the DAC underflow guard: FSM states, fill-mode
// encodings and a saturating increment.
package util_dac_underflow_guard_pkg;

  localparam int unsigned TS_WIDTH      = 64;
  localparam int unsigned SAT_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRIME     = 2'd1,
    ST_RUN       = 2'd2,
    ST_UNDERFLOW = 2'd3
  } state_t;

  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_HOLD = 1'b1;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] val,
    input logic [SAT_MAX_WIDTH-1:0] max_val
  );
    sat_inc = (val >= max_val) ? max_val : val + SAT_MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/util_sat_counter.sv
// Saturating statistics counter with a synchronous clear that wins over increment.
module util_sat_counter
  import util_dac_underflow_guard_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_inc,
  input  logic                   i_clr,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam logic [SAT_MAX_WIDTH-1:0] MAX_VAL = SAT_MAX_WIDTH'({COUNT_WIDTH{1'b1}});

  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(r_count), MAX_VAL));
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/util_dac_underflow_guard.sv
// DAC-side stream guard: forwards unpacked samples on each DAC strobe and
// substitutes fill samples when the stream stalls, tracking underflow statistics.
module util_dac_underflow_guard
  import util_dac_underflow_guard_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned CHANNEL_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH   = 32
) (
  input  logic                   dac_clk,
  input  logic                   reset,
  input  logic [TS_WIDTH-1:0]    timestamp,
  input  logic                   xfer_req,
  input  logic                   fill_mode,
  input  logic                   clear_stats,
  input  logic                   dac_valid,
  input  logic                   s_axis_valid,
  output logic                   s_axis_ready,
  input  logic [DATA_WIDTH-1:0]  s_axis_data,
  output logic [DATA_WIDTH-1:0]  dac_data,
  output logic                   underflow,
  output logic                   underflow_sticky,
  output logic [COUNT_WIDTH-1:0] underflow_runs,
  output logic [COUNT_WIDTH-1:0] underflow_samples,
  output logic [TS_WIDTH-1:0]    underflow_ts
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / CHANNEL_WIDTH;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_accept;
  logic                    w_fill;
  logic                    w_run_start;
  logic [DATA_WIDTH-1:0]   w_hold;
  logic [DATA_WIDTH-1:0]   w_fill_data;
  logic [DATA_WIDTH-1:0]   r_dac_data;
  logic                    r_underflow;
  logic                    r_sticky;
  logic [TS_WIDTH-1:0]     r_ts;
  logic [CHANNEL_WIDTH-1:0] r_hold_lane [NUM_LANES];

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Strobe decode per state; xfer_req low overrides the next state only.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_fill       = 1'b0;
    w_run_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (xfer_req) begin
          w_next_state = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (dac_valid && s_axis_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dac_valid) begin
          if (s_axis_valid) begin
            w_accept = 1'b1;
          end else begin
            w_fill       = 1'b1;
            w_run_start  = 1'b1;
            w_next_state = ST_UNDERFLOW;
          end
        end
      end
      ST_UNDERFLOW: begin
        if (dac_valid) begin
          if (s_axis_valid) begin
            w_accept     = 1'b1;
            w_next_state = ST_RUN;
          end else begin
            w_fill = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (!xfer_req) begin
      w_next_state = ST_IDLE;
    end
  end

  assign s_axis_ready = dac_valid && (r_state != ST_IDLE);

  // Hold register kept per channel lane so hold-last repeats every channel's last sample.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    always_ff @(posedge dac_clk or posedge reset) begin
      if (reset) begin
        r_hold_lane[g] <= '0;
      end else if (w_accept) begin
        r_hold_lane[g] <= s_axis_data[g*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
    end
    assign w_hold[g*CHANNEL_WIDTH +: CHANNEL_WIDTH] = r_hold_lane[g];
  end

  assign w_fill_data = (fill_mode == FILL_HOLD) ? w_hold : '0;

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      r_dac_data <= '0;
    end else if (dac_valid) begin
      if (w_accept) begin
        r_dac_data <= s_axis_data;
      end else if (w_fill) begin
        r_dac_data <= w_fill_data;
      end else begin
        r_dac_data <= '0;
      end
    end
  end

  // Run-start pulse, sticky flag and run-start timestamp.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
      r_sticky    <= 1'b0;
      r_ts        <= '0;
    end else begin
      r_underflow <= w_run_start;
      if (clear_stats) begin
        r_sticky <= 1'b0;
      end else if (w_run_start) begin
        r_sticky <= 1'b1;
      end
      if (w_run_start) begin
        r_ts <= timestamp;
      end
    end
  end

  util_sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_runs (
    .i_clk   (dac_clk),
    .i_rst   (reset),
    .i_inc   (w_run_start),
    .i_clr   (clear_stats),
    .o_count (underflow_runs)
  );

  util_sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_samples (
    .i_clk   (dac_clk),
    .i_rst   (reset),
    .i_inc   (w_fill),
    .i_clr   (clear_stats),
    .o_count (underflow_samples)
  );

  assign dac_data         = r_dac_data;
  assign underflow        = r_underflow;
  assign underflow_sticky = r_sticky;
  assign underflow_ts     = r_ts;

endmodule

// File: tb/tb_util_dac_underflow_guard.sv
// Scoreboard bench for util_dac_underflow_guard: stimulus pushes expected DAC words,
// a monitor pops and compares one cycle after every strobe.
module tb_util_dac_underflow_guard;

  localparam logic [63:0] S0 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] S1 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] S2 = 64'h000C_000B_000A_0009;
  localparam logic [63:0] S3 = 64'h0010_000F_000E_000D;
  localparam logic [63:0] S4 = 64'h0014_0013_0012_0011;
  localparam logic [63:0] S5 = 64'h0018_0017_0016_0015;
  localparam logic [63:0] S6 = 64'h001C_001B_001A_0019;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  logic        dac_clk = 1'b0;
  logic        reset;
  logic [63:0] timestamp;
  logic        xfer_req;
  logic        fill_mode;
  logic        clear_stats;
  logic        dac_valid;
  logic        s_axis_valid;
  logic [63:0] s_axis_data;

  logic        s_axis_ready;
  logic [63:0] dac_data;
  logic        underflow;
  logic        underflow_sticky;
  logic [31:0] underflow_runs;
  logic [31:0] underflow_samples;
  logic [63:0] underflow_ts;

  logic        sm_ready;
  logic [63:0] sm_data;
  logic        sm_underflow;
  logic        sm_sticky;
  logic [1:0]  sm_runs;
  logic [1:0]  sm_samples;
  logic [63:0] sm_ts;

  typedef struct packed {
    logic [63:0] data;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic strobe_d = 1'b0;

  always #5 dac_clk = ~dac_clk;

  util_dac_underflow_guard #(
    .DATA_WIDTH(64), .CHANNEL_WIDTH(16), .COUNT_WIDTH(32)
  ) dut (
    .dac_clk(dac_clk), .reset(reset), .timestamp(timestamp), .xfer_req(xfer_req),
    .fill_mode(fill_mode), .clear_stats(clear_stats), .dac_valid(dac_valid),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
    .dac_data(dac_data), .underflow(underflow), .underflow_sticky(underflow_sticky),
    .underflow_runs(underflow_runs), .underflow_samples(underflow_samples),
    .underflow_ts(underflow_ts)
  );

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
  util_dac_underflow_guard #(
    .DATA_WIDTH(64), .CHANNEL_WIDTH(16), .COUNT_WIDTH(2)
  ) dut_sat (
    .dac_clk(dac_clk), .reset(reset), .timestamp(timestamp), .xfer_req(xfer_req),
    .fill_mode(fill_mode), .clear_stats(clear_stats), .dac_valid(dac_valid),
    .s_axis_valid(s_axis_valid), .s_axis_ready(sm_ready), .s_axis_data(s_axis_data),
    .dac_data(sm_data), .underflow(sm_underflow), .underflow_sticky(sm_sticky),
    .underflow_runs(sm_runs), .underflow_samples(sm_samples),
    .underflow_ts(sm_ts)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge dac_clk) strobe_d <= dac_valid && !reset;

  // Monitor: every strobe must yield exactly the queued word and pulse state.
  always @(negedge dac_clk) begin
    if (strobe_d) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_empty: output at %0t with no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (dac_data === e.data && underflow === e.uf) n_pass++;
        else $display("FAIL sb_out: got data=0x%0h uf=%0b expected data=0x%0h uf=%0b",
                      dac_data, underflow, e.data, e.uf);
      end
    end
  end

  task automatic strobe(input logic v, input logic [63:0] d, input logic [63:0] exp_d,
                        input logic exp_uf, input logic exp_rdy, input logic clr);
    dac_valid    = 1'b1;
    s_axis_valid = v;
    s_axis_data  = d;
    clear_stats  = clr;
    exp_q.push_back('{data: exp_d, uf: exp_uf});
    #1 check("s_axis_ready", 64'(s_axis_ready), 64'(exp_rdy));
    @(posedge dac_clk); #2;
    dac_valid    = 1'b0;
    s_axis_valid = 1'b0;
    clear_stats  = 1'b0;
    repeat (3) @(posedge dac_clk);
    #2;
  endtask

  task automatic check_stats(input string tag, input logic [31:0] runs, input logic [31:0] smp,
                             input logic sticky);
    check({tag, "_runs"},    64'(underflow_runs),    64'(runs));
    check({tag, "_samples"}, 64'(underflow_samples), 64'(smp));
    check({tag, "_sticky"},  64'(underflow_sticky),  64'(sticky));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; timestamp = '0; xfer_req = 1'b0; fill_mode = 1'b0;
    clear_stats = 1'b0; dac_valid = 1'b1; s_axis_valid = 1'b1; s_axis_data = JUNK;
    repeat (3) @(posedge dac_clk);
    #2;
    check("reset_ready", 64'(s_axis_ready), 64'd0);
    dac_valid = 1'b0; s_axis_valid = 1'b0;
    check("reset_dac_data", dac_data, 64'd0);
    check("reset_underflow", 64'(underflow), 64'd0);
    check("reset_ts", underflow_ts, 64'd0);
    check_stats("reset", 32'd0, 32'd0, 1'b0);

    reset = 1'b0; xfer_req = 1'b1;
    repeat (2) @(posedge dac_clk);
    #2;

    // Priming: empty strobes emit zero and are not underflow.
    for (int i = 0; i < 3; i++) strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    check_stats("prime", 32'd0, 32'd0, 1'b0);
    strobe(1'b1, S0, S0, 1'b0, 1'b1, 1'b0);
    strobe(1'b1, S1, S1, 1'b0, 1'b1, 1'b0);

    // Gap 1: zero fill.
    fill_mode = 1'b0; timestamp = 64'h100;
    strobe(1'b0, JUNK, 64'd0, 1'b1, 1'b1, 1'b0);
    timestamp = 64'h104;
    for (int i = 0; i < 4; i++) strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    check_stats("gap1", 32'd1, 32'd5, 1'b1);
    check("gap1_ts", underflow_ts, 64'h100);
    check("sat_gap1_samples", 64'(sm_samples), 64'd3);

    // Gap 2: hold-last fill repeats the last delivered word.
    strobe(1'b1, S2, S2, 1'b0, 1'b1, 1'b0);
    strobe(1'b1, S1, S1, 1'b0, 1'b1, 1'b0);
    fill_mode = 1'b1; timestamp = 64'h200;
    strobe(1'b0, JUNK, S1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b0, JUNK, S1, 1'b0, 1'b1, 1'b0);
    check_stats("gap2", 32'd2, 32'd10, 1'b1);
    check("gap2_ts", underflow_ts, 64'h200);

    // Two single-sample gaps; clear_stats coincides with the second.
    fill_mode = 1'b0;
    strobe(1'b1, S3, S3, 1'b0, 1'b1, 1'b0);
    timestamp = 64'h300;
    strobe(1'b0, JUNK, 64'd0, 1'b1, 1'b1, 1'b0);
    check_stats("gapa", 32'd3, 32'd11, 1'b1);
    check("gapa_ts", underflow_ts, 64'h300);
    strobe(1'b1, S4, S4, 1'b0, 1'b1, 1'b0);
    timestamp = 64'h400;
    strobe(1'b0, JUNK, 64'd0, 1'b1, 1'b1, 1'b1);
    check_stats("clear", 32'd0, 32'd0, 1'b0);
    check("clear_ts", underflow_ts, 64'h400);

    // Saturation on the narrow copy; wide copy keeps counting.
    strobe(1'b1, S5, S5, 1'b0, 1'b1, 1'b0);
    timestamp = 64'h500;
    strobe(1'b0, JUNK, 64'd0, 1'b1, 1'b1, 1'b0);
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    check("sat_samples_3", 64'(sm_samples), 64'd3);
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    check("sat_samples_hold", 64'(sm_samples), 64'd3);
    check("sat_runs", 64'(sm_runs), 64'd1);
    check_stats("wide", 32'd1, 32'd5, 1'b1);

    // Drop xfer_req mid-underflow: back to idle, zeros, not ready.
    xfer_req = 1'b0;
    repeat (2) @(posedge dac_clk);
    #2;
    strobe(1'b1, S6, 64'd0, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b0, 1'b0);
    check_stats("idle", 32'd1, 32'd5, 1'b1);

    // Re-arm: priming again without spurious underflow.
    xfer_req = 1'b1;
    repeat (2) @(posedge dac_clk);
    #2;
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, JUNK, 64'd0, 1'b0, 1'b1, 1'b0);
    check_stats("rearm", 32'd1, 32'd5, 1'b1);
    strobe(1'b1, S6, S6, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge dac_clk);
    #2;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
